dsss_tx_scheduler: RTL and testbench

- Frame-level transmit controller for the DSSS/BPSK transmit chain; runs on the sample clock clk2.
- Accepts a frame request and payload bytes over a valid/ready handshake, then generates the chip and bit timing strobes.
- Serialises preamble bits, then payload bits, MSB first, and gates the modulator enable.
- Closes each frame with a guard interval and a completion pulse; flags a payload underrun.

---
 rtl/dsss_tx_scheduler_if.sv | 28 ++
 rtl/dsss_tx_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_dsss_tx_scheduler.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dsss_tx_scheduler_if.sv
// Frame request, payload byte stream and transmit strobes of the DSSS/BPSK frame scheduler.
// The master side requests frames and supplies bytes; the slave side is the scheduler.
interface dsss_tx_scheduler_if #(
    parameter int LEN_W = 8
) ();
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             tx_bit;
    logic             tx_en;
    logic             chip_tick;
    logic             bit_tick;
    logic             busy;
    logic             frame_done;
    logic             underrun;

    modport master (
        output start, frame_len, in_valid, in_data,
        input  in_ready, tx_bit, tx_en, chip_tick, bit_tick, busy, frame_done, underrun
    );

    modport slave (
        input  start, frame_len, in_valid, in_data,
        output in_ready, tx_bit, tx_en, chip_tick, bit_tick, busy, frame_done, underrun
    );
endinterface

// File: rtl/dsss_tx_scheduler.sv
// Frame-level DSSS/BPSK transmit scheduler: chip/bit timing, preamble and payload
// serialisation (MSB first), one-byte holding buffer, guard interval and underrun flag.
module dsss_tx_scheduler #(
    parameter int                       CHIP_DIV         = 2500,
    parameter int                       CHIPS_PER_BIT    = 15,
    parameter int                       PREAMBLE_BITS    = 16,
    parameter logic [PREAMBLE_BITS-1:0] PREAMBLE_PATTERN = 16'hAAAA,
    parameter int                       GUARD_BITS       = 2,
    parameter int                       LEN_W            = 8
) (
    input  logic               clk2,
    input  logic               rst_n,
    dsss_tx_scheduler_if.slave bus
);
    localparam int CC_W    = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
    localparam int CI_W    = (CHIPS_PER_BIT > 1) ? $clog2(CHIPS_PER_BIT) : 1;
    localparam int BC_MAX0 = (PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8;
    localparam int BC_MAX  = (GUARD_BITS > BC_MAX0) ? GUARD_BITS : BC_MAX0;
    localparam int BC_W    = $clog2(BC_MAX);

    localparam logic [CC_W-1:0] CHIP_LAST  = CC_W'(CHIP_DIV - 1);
    localparam logic [CI_W-1:0] IDX_LAST   = CI_W'(CHIPS_PER_BIT - 1);
    localparam logic [BC_W-1:0] PRE_LAST   = BC_W'(PREAMBLE_BITS - 1);
    localparam logic [BC_W-1:0] BYTE_LAST  = BC_W'(7);
    localparam logic [BC_W-1:0] GUARD_LAST = BC_W'(GUARD_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_PAYLOAD,
        S_GUARD
    } state_t;

    state_t                   state_reg, state_next;
    logic [CC_W-1:0]          chip_cnt_reg, chip_cnt_next;
    logic [CI_W-1:0]          chip_idx_reg, chip_idx_next;
    logic [BC_W-1:0]          bit_idx_reg, bit_idx_next;
    logic [PREAMBLE_BITS-1:0] pre_shift_reg, pre_shift_next;
    logic [7:0]               shift_reg, shift_next;
    logic [7:0]               hold_data_reg, hold_data_next;
    logic                     hold_full_reg, hold_full_next;
    logic [LEN_W-1:0]         len_reg, len_next;
    logic [LEN_W-1:0]         fetched_reg, fetched_next;
    logic [LEN_W-1:0]         sent_reg, sent_next;
    logic                     underrun_reg, underrun_next;

    logic in_ready_reg, in_ready_next;
    logic tx_bit_reg, tx_bit_next;
    logic tx_en_reg, tx_en_next;
    logic chip_tick_reg, chip_tick_next;
    logic bit_tick_reg, bit_tick_next;
    logic busy_reg, busy_next;
    logic frame_done_reg, frame_done_next;

    logic chip_end;
    logic bit_end;
    logic take;
    logic load;

    always_comb begin
        state_next      = state_reg;
        chip_cnt_next   = chip_cnt_reg;
        chip_idx_next   = chip_idx_reg;
        bit_idx_next    = bit_idx_reg;
        pre_shift_next  = pre_shift_reg;
        shift_next      = shift_reg;
        hold_data_next  = hold_data_reg;
        hold_full_next  = hold_full_reg;
        len_next        = len_reg;
        fetched_next    = fetched_reg;
        sent_next       = sent_reg;
        underrun_next   = underrun_reg;
        frame_done_next = 1'b0;
        load            = 1'b0;

        chip_end = (state_reg != S_IDLE) && (chip_cnt_reg == CHIP_LAST);
        bit_end  = chip_end && (chip_idx_reg == IDX_LAST);
        take     = bus.in_valid && in_ready_reg;

        if (state_reg != S_IDLE) begin
            if (chip_end) begin
                chip_cnt_next = '0;
                chip_idx_next = bit_end ? '0 : chip_idx_reg + 1'b1;
            end else begin
                chip_cnt_next = chip_cnt_reg + 1'b1;
            end
        end

        case (state_reg)
            S_IDLE: begin
                if (bus.start && (bus.frame_len != '0)) begin
                    state_next     = S_PREAMBLE;
                    len_next       = bus.frame_len;
                    underrun_next  = 1'b0;
                    chip_cnt_next  = '0;
                    chip_idx_next  = '0;
                    bit_idx_next   = '0;
                    hold_full_next = 1'b0;
                    fetched_next   = '0;
                    sent_next      = '0;
                    pre_shift_next = PREAMBLE_PATTERN;
                end
            end
            S_PREAMBLE: begin
                if (bit_end) begin
                    if (bit_idx_reg == PRE_LAST) begin
                        bit_idx_next = '0;
                        if (hold_full_reg) begin
                            load       = 1'b1;
                            state_next = S_PAYLOAD;
                        end else begin
                            underrun_next = 1'b1;
                            state_next    = S_GUARD;
                        end
                    end else begin
                        bit_idx_next   = bit_idx_reg + 1'b1;
                        pre_shift_next = pre_shift_reg << 1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (bit_end) begin
                    if (bit_idx_reg == BYTE_LAST) begin
                        bit_idx_next = '0;
                        if (sent_reg == len_reg) begin
                            state_next = S_GUARD;
                        end else if (hold_full_reg) begin
                            load = 1'b1;
                        end else begin
                            // Byte not there in time: truncate the frame, drop the rest.
                            underrun_next = 1'b1;
                            state_next    = S_GUARD;
                        end
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                        shift_next   = shift_reg << 1;
                    end
                end
            end
            S_GUARD: begin
                if (bit_end) begin
                    if (bit_idx_reg == GUARD_LAST) begin
                        bit_idx_next    = '0;
                        state_next      = S_IDLE;
                        frame_done_next = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Drain before fill, so a same-cycle transfer leaves the buffer full.
        if (load) begin
            shift_next     = hold_data_reg;
            hold_full_next = 1'b0;
            sent_next      = sent_reg + 1'b1;
        end
        if (take) begin
            hold_data_next = bus.in_data;
            hold_full_next = 1'b1;
            fetched_next   = fetched_reg + 1'b1;
        end

        busy_next      = (state_next != S_IDLE);
        tx_en_next     = (state_next == S_PREAMBLE) || (state_next == S_PAYLOAD);
        chip_tick_next = busy_next && (chip_cnt_next == CHIP_LAST);
        bit_tick_next  = chip_tick_next && (chip_idx_next == IDX_LAST);
        in_ready_next  = tx_en_next && !hold_full_next && (fetched_next < len_next);
        tx_bit_next    = 1'b0;
        if (state_next == S_PREAMBLE) begin
            tx_bit_next = pre_shift_next[PREAMBLE_BITS-1];
        end else if (state_next == S_PAYLOAD) begin
            tx_bit_next = shift_next[7];
        end
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            chip_cnt_reg   <= '0;
            chip_idx_reg   <= '0;
            bit_idx_reg    <= '0;
            pre_shift_reg  <= '0;
            shift_reg      <= '0;
            hold_data_reg  <= '0;
            hold_full_reg  <= 1'b0;
            len_reg        <= '0;
            fetched_reg    <= '0;
            sent_reg       <= '0;
            underrun_reg   <= 1'b0;
            in_ready_reg   <= 1'b0;
            tx_bit_reg     <= 1'b0;
            tx_en_reg      <= 1'b0;
            chip_tick_reg  <= 1'b0;
            bit_tick_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            chip_cnt_reg   <= chip_cnt_next;
            chip_idx_reg   <= chip_idx_next;
            bit_idx_reg    <= bit_idx_next;
            pre_shift_reg  <= pre_shift_next;
            shift_reg      <= shift_next;
            hold_data_reg  <= hold_data_next;
            hold_full_reg  <= hold_full_next;
            len_reg        <= len_next;
            fetched_reg    <= fetched_next;
            sent_reg       <= sent_next;
            underrun_reg   <= underrun_next;
            in_ready_reg   <= in_ready_next;
            tx_bit_reg     <= tx_bit_next;
            tx_en_reg      <= tx_en_next;
            chip_tick_reg  <= chip_tick_next;
            bit_tick_reg   <= bit_tick_next;
            busy_reg       <= busy_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign bus.in_ready   = in_ready_reg;
    assign bus.tx_bit     = tx_bit_reg;
    assign bus.tx_en      = tx_en_reg;
    assign bus.chip_tick  = chip_tick_reg;
    assign bus.bit_tick   = bit_tick_reg;
    assign bus.busy       = busy_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.underrun   = underrun_reg;
endmodule

// File: tb/tb_dsss_tx_scheduler.sv
// Bench for dsss_tx_scheduler: frame table plus random frames, each checked cycle by cycle
// against a timeline model of the frame, and hand-written reset / ignored-start sequences.
module tb_dsss_tx_scheduler;
    localparam int             CD       = 4;
    localparam int             CPB      = 3;
    localparam int             BITP     = CD * CPB;
    localparam int             PRE_BITS = 4;
    localparam int             GUARD    = 1;
    localparam logic [3:0]     PAT      = 4'b1010;

    logic clk2;
    logic rst_n;

    dsss_tx_scheduler_if #(.LEN_W(8)) bus ();

    dsss_tx_scheduler #(
        .CHIP_DIV        (CD),
        .CHIPS_PER_BIT   (CPB),
        .PREAMBLE_BITS   (PRE_BITS),
        .PREAMBLE_PATTERN(PAT),
        .GUARD_BITS      (GUARD),
        .LEN_W           (8)
    ) dut (
        .clk2 (clk2),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] frame_bytes [256];

    typedef struct {
        int          len;
        int          supply;
        bit          noise;
        logic [31:0] data;
        int          exp_done;
        int          exp_hs;
        logic        exp_ur;
    } vec_t;

    vec_t vec [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // {busy, tx_en, tx_bit, chip_tick, bit_tick, in_ready, frame_done, underrun}
    function automatic logic [7:0] outs();
        return {bus.busy, bus.tx_en, bus.tx_bit, bus.chip_tick, bus.bit_tick,
                bus.in_ready, bus.frame_done, bus.underrun};
    endfunction

    // Runs one frame; cycle k = 0 is the first cycle after the accepting edge.
    task automatic run_frame(input int len, input int supply, input int pct, input bit noise,
                             output int done_at, output int hs, output logic ur_out);
        int   loaded, active_last, done_k, ur_k, limit, hs_before, pos, i;
        bit   ended, active, exp_busy, ebit;
        logic [7:0] exp_v, act_v, cur;
        logic [3:0] pat;
        pat         = PAT;
        hs          = 0;
        loaded      = 0;
        ended       = 1'b0;
        active_last = 0;
        done_k      = -1;
        ur_k        = -1;
        done_at     = -1;
        ur_out      = 1'bx;
        limit       = (PRE_BITS + 8 * len + GUARD) * BITP + 4;
        @(negedge clk2);
        bus.start     = 1'b1;
        bus.frame_len = 8'(len);
        bus.in_valid  = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk2);
            bus.start = 1'b0;
            active    = !ended || (k <= active_last);
            exp_busy  = !(ended && (k >= done_k));
            if (!active) begin
                ebit = 1'b0;
            end else if (k < PRE_BITS * BITP) begin
                ebit = pat[PRE_BITS - 1 - k / BITP];
            end else begin
                pos  = k / BITP - PRE_BITS;
                cur  = frame_bytes[pos / 8];
                ebit = cur[7 - pos % 8];
            end
            exp_v = {exp_busy, active, ebit,
                     exp_busy && (k % CD == CD - 1),
                     exp_busy && (k % BITP == BITP - 1),
                     active && (hs == loaded) && (hs < len),
                     ended && (k == done_k),
                     (ur_k >= 0) && (k > ur_k)};
            act_v = outs();
            check($sformatf("outputs len=%0d k=%0d", len, k), act_v, exp_v);
            if (act_v[1] && done_at < 0) done_at = k;
            if (ended && k == done_k) begin
                ur_out = bus.underrun;
                break;
            end
            bus.start     = noise && ($urandom_range(7) == 0);
            bus.frame_len = 8'($urandom_range(255));
            hs_before     = hs;
            bus.in_valid  = (hs < supply) && ($urandom_range(99) < pct);
            if (hs < supply) bus.in_data = frame_bytes[hs];
            if (bus.in_valid && bus.in_ready) hs++;
            // End of the preamble or of a byte: load the next byte, finish, or underrun.
            if (!ended && (k + 1 >= PRE_BITS * BITP) &&
                ((k + 1 - PRE_BITS * BITP) % (8 * BITP) == 0)) begin
                i = (k + 1 - PRE_BITS * BITP) / (8 * BITP);
                if (i == len) begin
                    ended       = 1'b1;
                    active_last = k;
                end else if (hs_before > i) begin
                    loaded = i + 1;
                end else begin
                    ended       = 1'b1;
                    active_last = k;
                    ur_k        = k;
                end
                if (ended) done_k = k + GUARD * BITP + 1;
            end
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int          done_at, hs, len, supply, pct;
        logic        ur;
        logic [31:0] word;

        vec[0] = '{1, 1, 1'b0, 32'hC500_0000, 156, 1, 1'b0};
        vec[1] = '{3, 3, 1'b0, 32'h01FF_8000, 348, 3, 1'b0};
        vec[2] = '{2, 1, 1'b0, 32'h3CA5_0000, 156, 1, 1'b1};
        vec[3] = '{1, 0, 1'b0, 32'h7700_0000, 60,  0, 1'b1};
        vec[4] = '{4, 4, 1'b1, 32'hDEAD_BEEF, 444, 4, 1'b0};
        vec[5] = '{2, 2, 1'b0, 32'h9612_0000, 252, 2, 1'b0};

        bus.start     = 1'b0;
        bus.frame_len = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk2);
        check("reset_outputs", outs(), 8'h00);
        rst_n = 1'b1;
        @(negedge clk2);
        check("idle_after_release", outs(), 8'h00);

        bus.start     = 1'b1;
        bus.frame_len = 8'd0;
        repeat (3) @(negedge clk2);
        check("len0_start_ignored", outs(), 8'h00);
        bus.start = 1'b0;

        for (int t = 0; t < 6; t++) begin
            word = vec[t].data;
            for (int b = 0; b < 4; b++) frame_bytes[b] = word[31 - 8 * b -: 8];
            run_frame(vec[t].len, vec[t].supply, 100, vec[t].noise, done_at, hs, ur);
            $display("vec%0d len=%0d supply=%0d done_at=%0d handshakes=%0d underrun=%0b",
                     t, vec[t].len, vec[t].supply, done_at, hs, ur);
            check($sformatf("vec%0d_done_cycle", t), 32'(done_at), 32'(vec[t].exp_done));
            check($sformatf("vec%0d_handshakes", t), 32'(hs), 32'(vec[t].exp_hs));
            check($sformatf("vec%0d_underrun", t), {31'd0, ur}, {31'd0, vec[t].exp_ur});
        end

        // Asynchronous reset in the middle of the payload.
        @(negedge clk2);
        bus.start     = 1'b1;
        bus.frame_len = 8'd2;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h5A;
        @(negedge clk2);
        bus.start = 1'b0;
        repeat (60) @(negedge clk2);
        check("busy_before_reset", {30'd0, bus.busy, bus.tx_en}, 32'd3);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", outs(), 8'h00);
        bus.in_valid = 1'b0;
        @(negedge clk2);
        rst_n = 1'b1;
        $display("mid-payload reset applied and released");

        for (int r = 0; r < 8; r++) begin
            len    = int'($urandom_range(6, 1));
            supply = ($urandom_range(1) == 1) ? len : int'($urandom_range(len, 0));
            pct    = int'($urandom_range(100, 5));
            for (int b = 0; b < len; b++) frame_bytes[b] = 8'($urandom);
            run_frame(len, supply, pct, 1'b1, done_at, hs, ur);
            $display("rand%0d len=%0d supply=%0d pct=%0d done_at=%0d handshakes=%0d underrun=%0b",
                     r, len, supply, pct, done_at, hs, ur);
            check($sformatf("rand%0d_hs_bound", r), {31'd0, (hs <= supply)}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
